// File: rtl/matrix_mult_ctrl.sv
// 4x4 matrix-multiply stage: reads A and B from the matrix RAM, forms C = A*B one
// element per cycle with four MAC lanes, and writes C back as a single RAM word.
module matrix_mult_ctrl #(
  parameter int ADDR_W = 4,
  parameter int ELEM_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [ADDR_W-1:0]     addr_c,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic                  mem_rw,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [16*ELEM_W-1:0]  mem_wdata,
  input  logic [16*ELEM_W-1:0]  mem_rdata
);

  // state   | meaning
  // IDLE    | waiting for start
  // RD_A    | read issued for operand A
  // RD_B    | read issued for B, A data arriving
  // LAT     | B data arriving
  // COMPUTE | one result element per cycle, idx 0..15
  // WRITE   | result word written to addr_c
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, LAT, COMPUTE, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]    a_q, b_q, c_q;
  logic [16*ELEM_W-1:0] a_mat, b_mat;
  logic [3:0]           idx;
  logic [1:0]           row, col;
  logic [ELEM_W-1:0]    a_el [4][4];
  logic [ELEM_W-1:0]    b_el [4][4];
  logic [ELEM_W-1:0]    c_el [16];
  logic [ELEM_W-1:0]    prod [4];
  logic [ELEM_W-1:0]    elem_sum;

  assign row = idx[3:2];
  assign col = idx[1:0];

  for (genvar gr = 0; gr < 4; gr++) begin : g_unpack_r
    for (genvar gc = 0; gc < 4; gc++) begin : g_unpack_c
      assign a_el[gr][gc] = a_mat[ELEM_W*(4*gr+gc) +: ELEM_W];
      assign b_el[gr][gc] = b_mat[ELEM_W*(4*gr+gc) +: ELEM_W];
    end
  end

  // The stored element is the sum modulo 2^ELEM_W, so keeping only the low
  // ELEM_W bits of every product and partial sum gives the identical result.
  for (genvar gk = 0; gk < 4; gk++) begin : g_lane
    assign prod[gk] = a_el[row][gk] * b_el[gk][col];
  end

  assign elem_sum = prod[0] + prod[1] + prod[2] + prod[3];

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign mem_wdata[ELEM_W*g +: ELEM_W] = c_el[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_en    = 1'b0;
    mem_rw    = 1'b1;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RD_A;
      end
      RD_A: begin
        mem_en    = 1'b1;
        mem_addr  = a_q;
        state_nxt = RD_B;
      end
      RD_B: begin
        mem_en    = 1'b1;
        mem_addr  = b_q;
        state_nxt = LAT;
      end
      LAT:     state_nxt = COMPUTE;
      COMPUTE: if (idx == 4'd15) state_nxt = WRITE;
      WRITE: begin
        mem_en    = 1'b1;
        mem_rw    = 1'b0;
        mem_addr  = c_q;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      a_mat <= '0;
      b_mat <= '0;
      idx   <= '0;
      c_el  <= '{default: '0};
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q <= addr_a;
          b_q <= addr_b;
          c_q <= addr_c;
        end
        RD_B: a_mat <= mem_rdata;
        LAT: begin
          b_mat <= mem_rdata;
          idx   <= '0;
        end
        COMPUTE: begin
          c_el[idx] <= elem_sum;
          idx       <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Bench for matrix_mult_ctrl: behavioural RAM, table-driven and random operations
// checked against a loop-based matrix product, plus busy/reset/held-start sequences.
module tb_matrix_mult_ctrl;
  localparam int WW = 256;

  typedef struct {
    logic [WW-1:0] aw;
    logic [WW-1:0] bw;
    logic [3:0]    a;
    logic [3:0]    b;
    logic [3:0]    c;
    logic [WW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    addr_a = '0, addr_b = '0, addr_c = '0;
  logic          busy, done, mem_en, mem_rw;
  logic [3:0]    mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;

  logic [WW-1:0] ram [16];
  logic          tb_we = 1'b0;
  logic [3:0]    tb_waddr = '0;
  logic [WW-1:0] tb_wdata = '0;

  int n_vec = 0, n_bad = 0;
  int n_writes = 0, n_done = 0;

  matrix_mult_ctrl #(.ADDR_W(4), .ELEM_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else if (mem_en && !mem_rw) ram[mem_addr] <= mem_wdata;
    if (mem_en && mem_rw) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_en && !mem_rw) n_writes++;
    if (done) n_done++;
  end

  function automatic logic [WW-1:0] fill(input logic [15:0] v);
    logic [WW-1:0] w;
    for (int i = 0; i < 16; i++) w[16*i +: 16] = v;
    return w;
  endfunction

  function automatic logic [WW-1:0] diag(input logic [15:0] v);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) w[16*(5*r) +: 16] = v;
    return w;
  endfunction

  function automatic logic [WW-1:0] ramp();
    logic [WW-1:0] w;
    for (int i = 0; i < 16; i++) w[16*i +: 16] = 16'(i);
    return w;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  // Reference: textbook triple loop with wide sums, truncated at the end.
  function automatic logic [WW-1:0] matmul(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [WW-1:0] res;
    longint unsigned s;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += longint'(a[16*(4*r+k) +: 16]) * longint'(b[16*(4*k+c) +: 16]);
        res[16*(4*r+c) +: 16] = s[15:0];
      end
    return res;
  endfunction

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [WW-1:0] w);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = w;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Pulses start; returns at the first negedge after the accepting edge (n=1).
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    addr_a = a; addr_b = b; addr_c = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_ok);
    lat = -1;
    busy_ok = 1;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (!busy) busy_ok = 0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t vecs[$];
  vec_t v;
  int lat, busy_ok, w0, d0, d1, d2;

  initial begin
    vecs.push_back('{diag(16'h0001), ramp(), 4'd0, 4'd1, 4'd2, ramp()});
    vecs.push_back('{fill(16'h0002), fill(16'h0003), 4'd3, 4'd4, 4'd5, fill(16'h0018)});
    vecs.push_back('{fill(16'h0100), fill(16'h0100), 4'd0, 4'd1, 4'd2, fill(16'h0000)});
    vecs.push_back('{fill(16'hFFFF), fill(16'h0001), 4'd0, 4'd1, 4'd2, fill(16'hFFFC)});
    for (int i = 0; i < 8; i++) begin
      v.aw = rand_word(); v.bw = rand_word();
      v.a = 4'($urandom_range(0, 15)); v.b = 4'($urandom_range(0, 15));
      v.c = 4'($urandom_range(0, 15));
      if (v.a == v.b) v.aw = v.bw;
      v.exp = matmul(v.aw, v.bw);
      vecs.push_back(v);
    end

    #7;
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_mem_en", int'(mem_en), 0);
    check_int("reset_mem_rw", int'(mem_rw), 1);
    check_int("reset_mem_addr", int'(mem_addr), 0);
    check("reset_mem_wdata", mem_wdata, '0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      load(vecs[i].a, vecs[i].aw);
      load(vecs[i].b, vecs[i].bw);
      launch(vecs[i].a, vecs[i].b, vecs[i].c);
      wait_done(lat, busy_ok);
      check_int($sformatf("latency_%0d", i), lat, 21);
      check_int($sformatf("busy_%0d", i), busy_ok, 1);
      check($sformatf("result_%0d", i), ram[vecs[i].c], vecs[i].exp);
    end
    @(negedge clk);
    check_int("idle_after_done", int'(busy), 0);

    // In-place: C overwrites A
    load(4'd6, diag(16'h0001));
    load(4'd7, diag(16'h0002));
    launch(4'd6, 4'd7, 4'd6);
    wait_done(lat, busy_ok);
    check("inplace_c", ram[6], diag(16'h0002));
    check("inplace_b_kept", ram[7], diag(16'h0002));

    // Second start mid-compute must be ignored
    load(4'd11, diag(16'h0003));
    load(4'd12, ramp());
    load(4'd14, fill(16'h1111));
    w0 = n_writes; d0 = n_done;
    launch(4'd11, 4'd12, 4'd13);
    repeat (9) @(negedge clk);
    addr_a = 4'd0; addr_b = 4'd0; addr_c = 4'd14; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check_int("busy_start_dones", n_done - d0, 1);
    check_int("busy_start_writes", n_writes - w0, 1);
    check("busy_start_result", ram[13], matmul(diag(16'h0003), ramp()));
    check("busy_start_no_stray", ram[14], fill(16'h1111));

    // Reset at compute element 8 aborts without write or done
    load(4'd8, fill(16'h0005));
    load(4'd9, fill(16'h0007));
    load(4'd10, fill(16'hABCD));
    launch(4'd8, 4'd9, 4'd10);
    repeat (11) @(negedge clk);
    w0 = n_writes; d0 = n_done;
    reset = 1'b1;
    #1;
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_mem_en", int'(mem_en), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_c_kept", ram[10], fill(16'hABCD));
    check_int("abort_writes", n_writes - w0, 0);
    check_int("abort_dones", n_done - d0, 0);

    // start held high: back-to-back operations
    load(4'd1, fill(16'h0002));
    load(4'd2, fill(16'h0002));
    d1 = -1; d2 = -1;
    @(negedge clk);
    addr_a = 4'd1; addr_b = 4'd2; addr_c = 4'd3; start = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (d2 >= 0) break;
    end
    start = 1'b0;
    check_int("held_first_done", d1, 21);
    check_int("held_second_done", d2, 43);
    repeat (3) @(negedge clk);
    check_int("held_idle", int'(busy), 0);
    check("held_result", ram[3], fill(16'h0010));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
